// File: rtl/glb_bank_sram_ctrl_pkg.sv
// Global-buffer bank shared constants and SRAM command encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package glb_bank_sram_ctrl_pkg;

  localparam int GLB_DATA_WIDTH        = 64;
  localparam int GLB_ADDR_WIDTH        = 14;
  localparam int GLB_SRAM_READ_LATENCY = 3;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_RD   = 2'd1,
    SRAM_WR   = 2'd2
  } sram_cmd_e;

endpackage

// File: rtl/glb_bank_sram_ctrl_rsp_fifo.sv
// Read-response FIFO for a global-buffer bank, modulo-DEPTH pointers.
// Latency: push visible at head one cycle later (no bypass).
// Backpressure: push ignored when full, pop ignored when empty.
module glb_bank_rsp_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/glb_bank_sram_ctrl.sv
// Global-buffer bank controller: valid/ready requests to a registered single-port SRAM.
// Latency: read data on rsp_* READ_LATENCY+2 cycles after acceptance; writes silent.
// Backpressure: credit counter holds req_ready low while the response FIFO could overflow.
module glb_bank_sram_ctrl
  import glb_bank_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = GLB_DATA_WIDTH,
  parameter int ADDR_WIDTH   = GLB_ADDR_WIDTH,
  parameter int READ_LATENCY = GLB_SRAM_READ_LATENCY
) (
  input  logic                    CLK,
  input  logic                    RSTB,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    sram_ceb,
  output logic                    sram_web,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic [DATA_WIDTH-1:0]   sram_d,
  output logic [DATA_WIDTH-1:0]   sram_bweb,
  input  logic [DATA_WIDTH-1:0]   sram_q
);
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  sram_cmd_e               cmd;
  logic [DATA_WIDTH-1:0]   wr_bweb;
  logic                    rd_issued;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic                    q_vld;
  logic                    rsp_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        outstanding;
  logic                    unused_fifo_status;

  assign req_ready = (outstanding < CNT_W'(FIFO_DEPTH));
  assign rsp_valid = ~fifo_empty;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rd_issued = ~sram_ceb & sram_web;
  assign unused_fifo_status = fifo_full ^ (^fifo_count);

  always_comb begin
    cmd = SRAM_IDLE;
    if (req_valid && req_ready) cmd = req_wr ? SRAM_WR : SRAM_RD;
  end

  always_comb begin
    wr_bweb = '1;
    for (int i = 0; i < DATA_WIDTH; i++) wr_bweb[i] = ~req_wstrb[i/8];
  end

  // Address and write data hold when idle so the SRAM pins only toggle on real accesses.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sram_ceb  <= 1'b1;
      sram_web  <= 1'b1;
      sram_bweb <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
    end else begin
      case (cmd)
        SRAM_WR: begin
          sram_ceb  <= 1'b0;
          sram_web  <= 1'b0;
          sram_a    <= req_addr;
          sram_d    <= req_wdata;
          sram_bweb <= wr_bweb;
        end
        SRAM_RD: begin
          sram_ceb  <= 1'b0;
          sram_web  <= 1'b1;
          sram_a    <= req_addr;
          sram_bweb <= '1;
        end
        default: begin
          sram_ceb  <= 1'b1;
          sram_web  <= 1'b1;
          sram_bweb <= '1;
        end
      endcase
    end
  end

  // rd_pipe follows the SRAM's internal latency; q_vld marks the cycle sram_q is stable.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      rd_pipe <= '0;
      q_vld   <= 1'b0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | READ_LATENCY'(rd_issued);
      q_vld   <= rd_pipe[READ_LATENCY-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      outstanding <= '0;
    end else if ((cmd == SRAM_RD) && !rsp_pop) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if ((cmd != SRAM_RD) && rsp_pop) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  glb_bank_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .push     (q_vld),
    .push_dat (sram_q),
    .pop      (rsp_pop),
    .head_dat (rsp_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_glb_bank_sram_ctrl.sv
// Bench for glb_bank_sram_ctrl: behavioural SRAM, queue-based response model, vectors + random traffic.
module tb_glb_bank_sram_ctrl;
  localparam int DW    = 64;
  localparam int AW    = 14;
  localparam int RL    = 3;
  localparam int DEPTH = RL + 2;

  logic          CLK;
  logic          RSTB;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [7:0]    req_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_bweb;
  logic [DW-1:0] sram_q;

  glb_bank_sram_ctrl dut (
    .CLK(CLK), .RSTB(RSTB),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a),
    .sram_d(sram_d), .sram_bweb(sram_bweb), .sram_q(sram_q)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural SRAM: read sampled at an edge appears on sram_q RL edges later, for one cycle.
  logic [DW-1:0] sram_mem [int];
  logic [DW-1:0] q_pipe [RL+1];

  function automatic logic [DW-1:0] sram_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : '0;
  endfunction

  always @(posedge CLK) begin
    for (int i = RL; i > 0; i--) q_pipe[i] <= q_pipe[i-1];
    if (!sram_ceb && sram_web) q_pipe[0] <= sram_rd(int'(sram_a));
    else q_pipe[0] <= 64'hDEAD_BEEF_DEAD_BEEF;
    if (!sram_ceb && !sram_web)
      sram_mem[int'(sram_a)] = (sram_rd(int'(sram_a)) & sram_bweb) | (sram_d & ~sram_bweb);
  end
  assign sram_q = q_pipe[RL];

  logic push_full_seen = 1'b0;
  always @(posedge CLK)
    if (RSTB && dut.u_rsp_fifo.push && dut.u_rsp_fifo.full) push_full_seen <= 1'b1;

  // Reference model: byte-merged memory image and an ordered queue of expected responses.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mmem [int];
  int            cyc;
  logic          last_acc;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] mrd(input int a);
    return mmem.exists(a) ? mmem[a] : '0;
  endfunction

  function automatic logic exp_rsp_vld();
    return (exp_q.size() > 0) && (exp_q[0].t <= cyc);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cyc = 0;
  endtask

  // Advances one clock: model updates at the edge, DUT outputs checked at the following negedge.
  task automatic tick();
    logic          acc;
    logic          pop;
    logic [DW-1:0] m;
    exp_t          e;
    acc = req_valid && (exp_q.size() < DEPTH);
    pop = exp_rsp_vld() && rsp_ready;
    @(posedge CLK);
    cyc++;
    if (pop) e = exp_q.pop_front();
    if (acc) begin
      if (req_wr) begin
        m = mrd(int'(req_addr));
        for (int b = 0; b < 8; b++) if (req_wstrb[b]) m[8*b +: 8] = req_wdata[8*b +: 8];
        mmem[int'(req_addr)] = m;
      end else begin
        e.d = mrd(int'(req_addr));
        e.t = cyc + RL + 2;
        exp_q.push_back(e);
      end
    end
    last_acc = acc;
    @(negedge CLK);
    chk("req_ready", {63'd0, req_ready}, {63'd0, exp_q.size() < DEPTH});
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_rsp_vld()});
    if (exp_rsp_vld()) chk("rsp_data", rsp_data, exp_q[0].d);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    wstrb;
    logic [DW-1:0] bweb;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t          vecs[7];
  logic [DW-1:0] last_d;
  logic [DW-1:0] popped[$];
  int            lat;
  int            acc_dut;
  int            acc_model;
  int            rd_i;

  initial begin
    vecs[0] = '{1'b1, 14'h0005, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 64'h0};
    vecs[1] = '{1'b0, 14'h0005, 64'h0, 8'h00, '1, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{1'b1, 14'h3FFF, '1, 8'h0F, 64'hFFFF_FFFF_0000_0000, 64'h0};
    vecs[3] = '{1'b0, 14'h3FFF, 64'h0, 8'h00, '1, 64'h0000_0000_FFFF_FFFF};
    vecs[4] = '{1'b1, 14'h0010, 64'h1122_3344_5566_7788, 8'hA5, 64'h00FF_00FF_FF00_FF00, 64'h0};
    vecs[5] = '{1'b0, 14'h0010, 64'h0, 8'h00, '1, 64'h1100_3300_0066_0088};
    vecs[6] = '{1'b0, 14'h3FF0, 64'h0, 8'h00, '1, 64'h0};

    RSTB = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
    last_d = '0;
    model_reset();

    @(negedge CLK);
    chk("rst_ceb", {63'd0, sram_ceb}, 64'd1);
    chk("rst_web", {63'd0, sram_web}, 64'd1);
    chk("rst_bweb", sram_bweb, '1);
    chk("rst_a", {50'd0, sram_a}, 64'd0);
    chk("rst_d", sram_d, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    RSTB = 1'b1;
    #1;
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

    // Directed single requests: SRAM pin image, hold behaviour and read latency.
    for (int v = 0; v < 7; v++) begin
      req_valid = 1'b1; req_wr = vecs[v].wr; req_addr = vecs[v].addr;
      req_wdata = vecs[v].wdata; req_wstrb = vecs[v].wstrb;
      tick();
      req_valid = 1'b0;
      chk("vec_ceb", {63'd0, sram_ceb}, 64'd0);
      chk("vec_web", {63'd0, sram_web}, {63'd0, ~vecs[v].wr});
      chk("vec_a", {50'd0, sram_a}, {50'd0, vecs[v].addr});
      chk("vec_bweb", sram_bweb, vecs[v].bweb);
      if (vecs[v].wr) last_d = vecs[v].wdata;
      chk("vec_d", sram_d, last_d);
      if (vecs[v].wr) begin
        tick();
        chk("idle_ceb", {63'd0, sram_ceb}, 64'd1);
        chk("idle_a_hold", {50'd0, sram_a}, {50'd0, vecs[v].addr});
        chk("idle_bweb", sram_bweb, '1);
      end else begin
        lat = 0;
        while (!rsp_valid && lat < 20) begin
          tick();
          lat++;
        end
        chk("rd_latency", 64'(lat), 64'(RL + 2));
        chk("vec_rdata", rsp_data, vecs[v].rdata);
        tick();
      end
    end

    // Write immediately followed by a read of the same word.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 14'h0020;
    req_wdata = 64'hFEED_FACE_CAFE_BABE; req_wstrb = 8'hFF;
    tick();
    req_wr = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int n = 0; n < 8; n++) tick();

    // Fill the response FIFO with rsp_ready low, then drain in order.
    req_valid = 1'b1; req_wr = 1'b1; req_wstrb = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      req_addr = 14'(14'h100 + i);
      req_wdata = 64'hC0DE_0000_0000_0000 | 64'(i);
      tick();
    end
    req_wr = 1'b0; rsp_ready = 1'b0; acc_dut = 0; rd_i = 0;
    for (int n = 0; n < 12; n++) begin
      req_addr = 14'(14'h100 + rd_i);
      if (req_ready) begin
        acc_dut++;
        rd_i++;
      end
      tick();
    end
    chk("stall_accepts", 64'(acc_dut), 64'd5);
    chk("stall_ready_low", {63'd0, req_ready}, 64'd0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    popped.delete();
    for (int n = 0; n < 8; n++) begin
      if (rsp_valid) popped.push_back(rsp_data);
      tick();
      if (n == 0) chk("ready_after_first_pop", {63'd0, req_ready}, 64'd1);
    end
    chk("drain_count", 64'(popped.size()), 64'd5);
    for (int i = 0; i < popped.size(); i++)
      chk("drain_order", popped[i], 64'hC0DE_0000_0000_0000 | 64'(i));

    // Streaming reads with the consumer always ready.
    req_valid = 1'b1; req_wr = 1'b0; acc_dut = 0; acc_model = 0;
    for (int n = 0; n < 20; n++) begin
      req_addr = 14'(14'h100 + $urandom_range(0, 4));
      if (req_ready) acc_dut++;
      tick();
      if (last_acc) acc_model++;
    end
    req_valid = 1'b0;
    chk("stream_accepts", 64'(acc_dut), 64'(acc_model));
    for (int n = 0; n < 10; n++) tick();

    // Random mixed traffic with random consumer backpressure.
    for (int n = 0; n < 400; n++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_wr    = ($urandom_range(0, 2) == 0);
      req_addr  = 14'(14'h200 + $urandom_range(0, 15));
      req_wdata = {$urandom, $urandom};
      req_wstrb = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int n = 0; n < 12; n++) tick();
    chk("random_drained", {63'd0, rsp_valid}, 64'd0);

    // Reset with three reads in flight.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 14'h0100;
    for (int n = 0; n < 3; n++) tick();
    req_valid = 1'b0;
    #2 RSTB = 1'b0;
    #1;
    chk("arst_ceb", {63'd0, sram_ceb}, 64'd1);
    chk("arst_web", {63'd0, sram_web}, 64'd1);
    chk("arst_bweb", sram_bweb, '1);
    chk("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RSTB = 1'b1;
    #1;
    chk("arst_ready_after", {63'd0, req_ready}, 64'd1);
    for (int n = 0; n < 10; n++) tick();

    chk("no_push_into_full", {63'd0, push_full_seen}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glb_bank_sram_ctrl.md
GLB_BANK_SRAM_CTRL -- requirements
Module: glb_bank_sram_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, word-address width.
REQ-003 SHALL have parameter READ_LATENCY, default 3, edges from SRAM-port sample to valid sram_q.
REQ-004 SHALL have ports: CLK input 1 clock; RSTB input 1 asynchronous active-low reset.
REQ-005 SHALL have ports: req_valid input 1; req_ready output 1; req_wr input 1 (1=write); req_addr input ADDR_WIDTH; req_wdata input DATA_WIDTH; req_wstrb input DATA_WIDTH/8 byte enables.
REQ-006 SHALL have ports: rsp_valid output 1; rsp_ready input 1; rsp_data output DATA_WIDTH read data.
REQ-007 SHALL have SRAM-side ports: sram_ceb output 1; sram_web output 1; sram_a output ADDR_WIDTH; sram_d output DATA_WIDTH; sram_bweb output DATA_WIDTH (active-low bit write enable); sram_q input DATA_WIDTH.

Function
REQ-008 SHALL accept a request at a rising CLK edge where req_valid and req_ready are both 1.
REQ-009 SHALL drive all sram_* outputs from flops; an accepted request at edge k SHALL appear on sram_* during cycle k..k+1.
REQ-010 Accepted write SHALL drive sram_ceb=0, sram_web=0, sram_a=req_addr, sram_d=req_wdata, sram_bweb bit i = ~req_wstrb[i/8].
REQ-011 Accepted read SHALL drive sram_ceb=0, sram_web=1, sram_a=req_addr, sram_bweb all ones; sram_d holds.
REQ-012 Cycle with no acceptance SHALL drive sram_ceb=1, sram_web=1, sram_bweb all ones; sram_a and sram_d hold previous values.
REQ-013 SHALL track each issued read in a READ_LATENCY-deep valid shift register started at edge k+1; sram_q SHALL be captured into the response FIFO at edge k+2+READ_LATENCY.
REQ-014 Response FIFO depth FIFO_DEPTH SHALL be READ_LATENCY+2; no bypass; first rsp_valid for a read accepted at edge k SHALL be in the cycle after edge k+2+READ_LATENCY.
REQ-015 Responses SHALL return in request order; writes SHALL produce no response.
REQ-016 SHALL keep credit counter outstanding (0..FIFO_DEPTH): +1 on read acceptance, -1 on rsp handshake, unchanged when both occur in the same edge.
REQ-017 req_ready SHALL equal (outstanding < FIFO_DEPTH), independent of req_wr and req_valid.
REQ-018 rsp_valid SHALL equal FIFO non-empty; rsp_data SHALL be FIFO head; head pops on rsp_valid & rsp_ready.
REQ-019 FIFO push and pop in the same edge SHALL leave occupancy unchanged; push into a full FIFO SHALL be impossible by construction (assertion in bench).
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH with no data loss.
REQ-021 Write followed next cycle by read to same address SHALL return the written data (SRAM ordering preserved, no reordering in block).

Reset
REQ-022 RSTB low SHALL asynchronously set: sram_ceb=1, sram_web=1, sram_bweb all ones, sram_a=0, sram_d=0, rsp_valid=0, rsp_data=0, outstanding=0, FIFO empty, valid shift register cleared.
REQ-023 req_ready SHALL be 1 in the first cycle after RSTB deasserts.
REQ-024 Reset mid-operation SHALL discard all in-flight reads and queued responses; no rsp_valid for them after release.

Structure
REQ-025 GLB_DATA_WIDTH, GLB_ADDR_WIDTH and GLB_SRAM_READ_LATENCY SHALL live in the shared global-buffer package and feed the default parameters.
REQ-026 Response FIFO SHALL be one sub-module, glb_bank_rsp_fifo (parameterised width/depth, async active-low reset, push/pop/full/empty/count).

Verification
REQ-027 Single write addr 0x005, wdata 0x0123_4567_89AB_CDEF, wstrb 0xFF, then read 0x005 -> rsp_data 0x0123_4567_89AB_CDEF, rsp_valid exactly READ_LATENCY+2 cycles after read acceptance (5 at default).
REQ-028 Partial write wstrb 0x0F data all-ones over prior 0 at addr 0x3FFF -> read returns 0x0000_0000_FFFF_FFFF; sram_bweb during write = 0xFFFF_FFFF_0000_0000.
REQ-029 rsp_ready held 0, back-to-back reads -> exactly 5 accepted, req_ready 0 thereafter; release rsp_ready -> 5 responses in issue order, req_ready returns 1 one cycle after first pop.
REQ-030 Continuous reads with rsp_ready=1 for 20 cycles -> one request accepted every cycle, no stall, FIFO wraps, data matches model.
REQ-031 Assert RSTB with 3 reads in flight -> sram_ceb=1 immediately, rsp_valid stays 0 after release, req_ready=1 next cycle.
